// File: rtl/circ_fifo_pkg.sv
// Shared sizing helpers for circ_fifo: pointer-width function and wrap-bit position.
package circ_fifo_pkg;

    // Ceiling log2; used at elaboration time to size pointer indices.
    function automatic int cf_clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    localparam int CF_DEFAULT_DEPTH = 8;
    localparam int CF_WRAP_BIT      = cf_clog2(CF_DEFAULT_DEPTH);

endpackage

// File: rtl/reg_.sv
// Write-enabled register with asynchronous active-low clear.
module reg_ #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_aL,
    input  logic             we,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] dout_q;

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL)  dout_q <= '0;
        else if (we)  dout_q <= din;
    end

    assign dout = dout_q;

endmodule

// File: rtl/up_counter.sv
// Free-running up counter with increment enable and asynchronous active-low reset.
module up_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_aL,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc) count_d = count_q + WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) count_q <= '0;
        else         count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/circ_fifo.sv
// Circular-buffer FIFO with valid/ready on both sides and wrap-bit pointers.
// Optional synchronous flush port enabled by defining CIRC_FIFO_FLUSH_EN.
module circ_fifo
    import circ_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = CF_DEFAULT_DEPTH,
    parameter int PTR_WIDTH  = cf_clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_aL,
`ifdef CIRC_FIFO_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  enq_valid,
    output logic                  enq_ready,
    input  logic [DATA_WIDTH-1:0] enq_data,
    output logic                  deq_valid,
    input  logic                  deq_ready,
    output logic [DATA_WIDTH-1:0] deq_data,
    output logic [PTR_WIDTH:0]    count,
    output logic                  full,
    output logic                  empty
);

    localparam int WRAP = PTR_WIDTH;

    logic                  enq_fire;
    logic                  deq_fire;
    logic                  tail_inc;
    logic [PTR_WIDTH:0]    head_q;
    logic [PTR_WIDTH:0]    tail_q;
    logic [PTR_WIDTH-1:0]  head_idx;
    logic [PTR_WIDTH-1:0]  tail_idx;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign enq_fire = enq_valid & enq_ready;
    assign deq_fire = deq_valid & deq_ready;

    assign head_idx = head_q[PTR_WIDTH-1:0];
    assign tail_idx = tail_q[PTR_WIDTH-1:0];

    up_counter #(.WIDTH(PTR_WIDTH + 1)) u_tail (
        .clk    (clk),
        .rst_aL (rst_aL),
        .inc    (tail_inc),
        .count  (tail_q)
    );

`ifdef CIRC_FIFO_FLUSH_EN
    // Flush collapses head onto tail and swallows any same-cycle enqueue.
    logic               head_we;
    logic [PTR_WIDTH:0] head_d;

    assign tail_inc = enq_fire & ~flush;
    assign head_we  = deq_fire | flush;
    assign head_d   = flush ? tail_q : head_q + (PTR_WIDTH + 1)'(1);

    reg_ #(.WIDTH(PTR_WIDTH + 1)) u_head (
        .clk    (clk),
        .rst_aL (rst_aL),
        .we     (head_we),
        .din    (head_d),
        .dout   (head_q)
    );
`else
    assign tail_inc = enq_fire;

    up_counter #(.WIDTH(PTR_WIDTH + 1)) u_head (
        .clk    (clk),
        .rst_aL (rst_aL),
        .inc    (deq_fire),
        .count  (head_q)
    );
`endif

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        reg_ #(.WIDTH(DATA_WIDTH)) u_entry (
            .clk    (clk),
            .rst_aL (rst_aL),
            .we     (tail_inc & (tail_idx == PTR_WIDTH'(i))),
            .din    (enq_data),
            .dout   (mem[i])
        );
    end

    // Wrap bit distinguishes full from empty when the indices coincide.
    assign empty     = (head_q == tail_q);
    assign full      = (head_idx == tail_idx) && (head_q[WRAP] != tail_q[WRAP]);
    assign count     = tail_q - head_q;
    assign enq_ready = ~full;
    assign deq_valid = ~empty;
    assign deq_data  = mem[head_idx];

endmodule

// File: tb/tb_circ_fifo.sv
// Scoreboard bench for circ_fifo (DATA_WIDTH=8, DEPTH=4); flush test runs when CIRC_FIFO_FLUSH_EN is defined.
module tb_circ_fifo;

    localparam int DW = 8;
    localparam int DP = 4;
    localparam int PW = 2;

    logic          clk;
    logic          rst_aL;
    logic          flush;
    logic          enq_valid;
    logic          enq_ready;
    logic [DW-1:0] enq_data;
    logic          deq_valid;
    logic          deq_ready;
    logic [DW-1:0] deq_data;
    logic [PW:0]   count;
    logic          full;
    logic          empty;

    int checks;
    int errors;
    logic [DW-1:0] exp_q [$];

    circ_fifo #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk       (clk),
        .rst_aL    (rst_aL),
`ifdef CIRC_FIFO_FLUSH_EN
        .flush     (flush),
`endif
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_data  (enq_data),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_data  (deq_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [DW-1:0] d, input bit expect_out);
        enq_valid = 1'b1;
        enq_data  = d;
        if (expect_out) exp_q.push_back(d);
        step();
        enq_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        deq_ready = 1'b1;
        repeat (n) step();
        deq_ready = 1'b0;
    endtask

    // Monitor: a handshake seen mid-cycle completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_aL && deq_valid && deq_ready && !flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL deq_unexpected: got 0x%0h expected no output", deq_data);
            end else begin
                check("deq_data", 32'(deq_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst_aL    = 1'b0;
        flush     = 1'b0;
        enq_valid = 1'b0;
        enq_data  = '0;
        deq_ready = 1'b0;
        repeat (2) step();
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_enq_ready", 32'(enq_ready), 32'd1);
        check("rst_deq_valid", 32'(deq_valid), 32'd0);
        check("rst_deq_data", 32'(deq_data), 32'd0);
        rst_aL = 1'b1;
        step();

        // Fill to full, then drain in order.
        enq(8'h11, 1'b1); enq(8'h22, 1'b1); enq(8'h33, 1'b1); enq(8'h44, 1'b1);
        check("t1_full", 32'(full), 32'd1);
        check("t1_count4", 32'(count), 32'd4);
        check("t1_enq_ready", 32'(enq_ready), 32'd0);
        drain(4);
        check("t1_empty", 32'(empty), 32'd1);
        check("t1_count0", 32'(count), 32'd0);

        // Full with simultaneous enq_valid/deq_ready: no bypass.
        enq(8'h11, 1'b1); enq(8'h22, 1'b1); enq(8'h33, 1'b1); enq(8'h44, 1'b1);
        enq_valid = 1'b1;
        enq_data  = 8'h55;
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;
        check("t2_count3", 32'(count), 32'd3);
        check("t2_enq_ready", 32'(enq_ready), 32'd1);
        exp_q.push_back(8'h55);
        step();
        enq_valid = 1'b0;
        check("t2_count4", 32'(count), 32'd4);
        drain(4);
        check("t2_empty", 32'(empty), 32'd1);

        // Steady state at count 2 across several pointer wraps.
        enq(8'h01, 1'b1); enq(8'h02, 1'b1);
        deq_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            enq_valid = 1'b1;
            enq_data  = 8'(8'h03 + k);
            exp_q.push_back(8'(8'h03 + k));
            step();
            check("t3_count2", 32'(count), 32'd2);
        end
        enq_valid = 1'b0;
        drain(2);
        check("t3_empty", 32'(empty), 32'd1);

        // Single entry into empty FIFO: visible one cycle later.
        enq_valid = 1'b1;
        enq_data  = 8'hAA;
        check("t4_deq_valid_n", 32'(deq_valid), 32'd0);
        exp_q.push_back(8'hAA);
        step();
        enq_valid = 1'b0;
        check("t4_deq_valid_n1", 32'(deq_valid), 32'd1);
        check("t4_deq_data_n1", 32'(deq_data), 32'hAA);
        drain(1);

        // Asynchronous reset mid-cycle discards contents at once.
        enq(8'h31, 1'b0); enq(8'h32, 1'b0); enq(8'h33, 1'b0);
        check("t5_count3", 32'(count), 32'd3);
        #2;
        rst_aL = 1'b0;
        #1;
        check("t5_empty", 32'(empty), 32'd1);
        check("t5_count0", 32'(count), 32'd0);
        check("t5_deq_valid", 32'(deq_valid), 32'd0);
        check("t5_deq_data", 32'(deq_data), 32'd0);
        step();
        rst_aL = 1'b1;
        step();
        enq(8'h5A, 1'b1);
        check("t5_count1", 32'(count), 32'd1);
        check("t5_idx0_data", 32'(deq_data), 32'h5A);
        drain(1);
        check("t5_empty_end", 32'(empty), 32'd1);

`ifdef CIRC_FIFO_FLUSH_EN
        // Flush beats same-cycle enqueue and dequeue.
        enq(8'h61, 1'b0); enq(8'h62, 1'b0); enq(8'h63, 1'b0);
        flush     = 1'b1;
        enq_valid = 1'b1;
        enq_data  = 8'h77;
        deq_ready = 1'b1;
        step();
        flush     = 1'b0;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        check("t6_empty", 32'(empty), 32'd1);
        check("t6_count0", 32'(count), 32'd0);
        enq(8'h88, 1'b1);
        check("t6_count1", 32'(count), 32'd1);
        drain(1);
        check("t6_empty_end", 32'(empty), 32'd1);
`endif

        step();
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/circ_fifo.md
Name: circ_fifo

Overview:
- Circular-buffer FIFO with a valid/ready handshake on both sides.
- Head and tail pointers are built from up_counter instances: enqueue fires the tail counter's increment, dequeue fires the head counter's increment.
- Generic buffering primitive for the OOO core: instruction/issue queues and ROB-style in-order structures.
- Directly consumes the count output of up_counter and drives its inc input.

Parameters:
- DATA_WIDTH, 32, width of each entry.
- DEPTH, 8, number of entries; must be a power of 2 and at least 2.
- PTR_WIDTH, $clog2(DEPTH), index width. Pointers carry one extra wrap bit, so they are PTR_WIDTH+1 bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_aL  input  1  asynchronous, active-low reset.
- enq_valid  input  1  producer offers enq_data this cycle.
- enq_ready  output  1  FIFO can accept; equals !full.
- enq_data  input  DATA_WIDTH  entry to write.
- deq_valid  output  1  head entry is valid; equals !empty.
- deq_ready  input  1  consumer takes the head entry this cycle.
- deq_data  output  DATA_WIDTH  head entry, read combinationally from the storage array.
- count  output  PTR_WIDTH+1  number of occupied entries, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Reset (rst_aL low, asynchronous):
  - head = tail = 0, all storage entries = 0.
  - empty=1, full=0, count=0, enq_ready=1, deq_valid=0, deq_data=0.
- Fire conditions: enq_fire = enq_valid & enq_ready; deq_fire = deq_valid & deq_ready.
- Enqueue: on enq_fire, mem[tail[PTR_WIDTH-1:0]] <= enq_data and tail <= tail+1. Only the indexed entry is write-enabled.
- Dequeue: on deq_fire, head <= head+1. Storage is not cleared.
- Pointer arithmetic: pointers are PTR_WIDTH+1 bits and wrap modulo 2*DEPTH. The index is the low PTR_WIDTH bits.
  - empty = (head == tail).
  - full = low bits equal AND MSBs differ.
  - count = tail - head, computed modulo 2^(PTR_WIDTH+1).
- Latency:
  - Data enqueued in cycle N is visible on deq_data with deq_valid=1 in cycle N+1.
  - No combinational fall-through from enq to deq.
  - enq_ready does not depend on deq_ready; there is no bypass when full.
- Simultaneous enq_fire and deq_fire: both pointers advance and count is unchanged. This is legal whenever not full and not empty.
- Full: enq_ready=0 and enq_valid is ignored, even if deq_ready=1 in the same cycle. The slot opens in the next cycle.
- Empty: deq_valid=0 and deq_ready is ignored. deq_data shows the stale mem[head] and carries no meaning.
- Wrap-around: after 2*DEPTH enqueues and dequeues, pointers return to 0 with correct full/empty decoding throughout.
- Reset mid-operation: all contents are discarded immediately. There is no partial-state retention.
- No protocol assertions on the inputs. A producer holding enq_valid while full simply stalls.

Optional Feature:
- Macro: CIRC_FIFO_FLUSH_EN.
- When defined:
  - Adds input port flush (1 bit).
  - flush=1 at a rising edge sets head <= tail. The FIFO becomes empty next cycle; storage is untouched.
  - flush has priority over enq_fire and deq_fire in the same cycle: the enqueue is dropped and the dequeue is treated as not having happened.
  - enq_ready is not gated by flush.
  - The pointer counter needs a load path: head is a reg_ with we = deq_fire | flush and din muxed between head+1 and tail.
- When undefined: the port is absent and the logic is identical to the base behaviour.

Decomposition:
- Shared package or include defines:
  - the pointer-width macro/function (clog2) used to size PTR_WIDTH;
  - a localparam for the wrap-bit position;
  - no typedefs (Verilog-2001 style).
- Pointers:
  - tail: up_counter instance, WIDTH=PTR_WIDTH+1, inc=enq_fire.
  - head: up_counter instance, inc=deq_fire. Under CIRC_FIFO_FLUSH_EN, head is instead a reg_ plus adder with a load mux.
- Storage: DEPTH reg_ instances of DATA_WIDTH, each with we = enq_fire & (tail index == i). This is generated inline; no extra sub-module.
- Read mux: deq_data is a DEPTH:1 mux, inline.

Test Plan (DATA_WIDTH=8, DEPTH=4 unless noted):
1. Reset, then enqueue 0x11, 0x22, 0x33, 0x44 on consecutive cycles → full=1, count=4, enq_ready=0. Then dequeue 4 → deq_data 0x11, 0x22, 0x33, 0x44 in order, ending empty=1, count=0.
2. While full, hold enq_valid=1 with 0x55 and deq_ready=1 for one cycle → 0x11 pops and 0x55 is not accepted that cycle. Next cycle enq_ready=1, 0x55 is accepted and count returns to 4.
3. Steady state at count=2 with enq_fire and deq_fire every cycle for 20 cycles (pointers wrap 2.5 times) → count stays 2, and data emerges in order with 2-cycle residency.
4. Enqueue 0xAA into an empty FIFO at cycle N → deq_valid=0 in cycle N and deq_valid=1 with deq_data=0xAA in cycle N+1.
5. Enqueue 3 entries, then assert rst_aL low between clock edges → empty=1, count=0, deq_valid=0 immediately, without waiting for an edge. After release, a subsequent enqueue lands at index 0.
6. With CIRC_FIFO_FLUSH_EN, hold 3 entries and assert flush together with enq_valid (0x77) and deq_ready → next cycle empty=1, count=0, and 0x77 is not stored. A following enqueue/dequeue of 0x88 returns 0x88.
